cla_add_sequencer: RTL and testbench

- Multi-cycle wide adder controller that time-shares one external 16-bit carry-lookahead adder slice (CLA_16) to add WORDS*16-bit operands.
- Feeds one 16-bit slice per cycle, LSB slice first, and chains the carry through a register.
- Captures each slice result and reports sum, carry-out and signed overflow with a start/busy/done handshake.
- Sits between a requesting unit and the shared CLA_16 instance; the CLA itself stays purely combinational.

---
 rtl/cla_add_sequencer.sv | 141 ++++++++++++++
 tb/tb_cla_add_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_sequencer.sv
// rtl/cla_add_sequencer.sv - multi-cycle WORDS*16-bit adder sequencer around a shared CLA_16 slice
//
// Purpose: time-shares one external combinational 16-bit carry-lookahead adder to add
//          W = 16*WORDS bit operands, one slice per cycle, LSB slice first, with the
//          carry chained through a 1-bit register.
// Optional feature: define CLA_SEQ_SUB_EN to add the 'sub' input (A-B mode).
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   start, a, b, cin    request pulse and operands (latched when start is accepted)
//   sub                 (CLA_SEQ_SUB_EN only) 1 = subtract, latched with start
//   busy, done          RUN indicator, one-cycle result-valid pulse
//   sum, cout, ovf      W-bit result, MSB carry-out, signed overflow
//   cla_a, cla_b, cla_cin   slice operands and chained carry driven to CLA_16
//   cla_sum, cla_cout       CLA_16 results
module cla_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [16*WORDS-1:0]  a,
    input  logic [16*WORDS-1:0]  b,
    input  logic                 cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [16*WORDS-1:0]  sum,
    output logic                 cout,
    output logic                 ovf,
    output logic [15:0]          cla_a,
    output logic [15:0]          cla_b,
    output logic                 cla_cin,
    input  logic [15:0]          cla_sum,
    input  logic                 cla_cout
);

    localparam int W  = 16 * WORDS;
    localparam int IW = $clog2(WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    opa, opb;
    logic            accept, capture;
    logic            last_slice;
    logic [W-1:0]    b_eff;
    logic            cin_eff;

    // Subtraction is A + ~B + 1; storing B already inverted keeps the RUN
    // datapath and the overflow test identical for both modes.
`ifdef CLA_SEQ_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign last_slice = (idx == IW'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        capture = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                busy    = 1'b1;
                capture = 1'b1;
                if (last_slice) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    accept  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            opa   <= a;
            opb   <= b_eff;
            carry <= cin_eff;
            idx   <= '0;
        end else if (capture) begin
            sum[{idx, 4'b0000} +: 16] <= cla_sum;
            carry                     <= cla_cout;
            if (last_slice) begin
                cout <= cla_cout;
                ovf  <= (opa[W-1] == opb[W-1]) && (cla_sum[15] != opa[W-1]);
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // The shared CLA sees zeros whenever this block is not actively using it.
    assign cla_a   = busy ? opa[{idx, 4'b0000} +: 16] : 16'h0000;
    assign cla_b   = busy ? opb[{idx, 4'b0000} +: 16] : 16'h0000;
    assign cla_cin = busy & carry;

endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb/tb_cla_add_sequencer.sv - self-checking bench for cla_add_sequencer with a behavioural CLA_16
module tb_cla_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a, b;
    logic          cin;
    logic          sub;
    logic          busy, done;
    logic [W-1:0]  sum;
    logic          cout, ovf;
    logic [15:0]   cla_a, cla_b, cla_sum;
    logic          cla_cin, cla_cout;
    logic [16:0]   cla_res;

    int n_chk  = 0;
    int n_fail = 0;

    cla_add_sequencer #(.WORDS(WORDS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub      (sub),
`endif
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf),
        .cla_a    (cla_a),
        .cla_b    (cla_b),
        .cla_cin  (cla_cin),
        .cla_sum  (cla_sum),
        .cla_cout (cla_cout)
    );

    // Behavioural CLA_16: plain 16-bit add with carry.
    assign cla_res  = {1'b0, cla_a} + {1'b0, cla_b} + {16'h0000, cla_cin};
    assign cla_sum  = cla_res[15:0];
    assign cla_cout = cla_res[16];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: tracks how many edges have passed since an accepted start and
    // computes the full-width result with ordinary arithmetic.
    int            m_cnt = 0;
    logic [W-1:0]  m_a, m_b;
    logic          m_c;
    logic [W-1:0]  e_sum = '0;
    logic          e_cout = 1'b0, e_ovf = 1'b0;

    always @(posedge clk) begin
        logic          s_start, s_cin, s_sub;
        logic [W-1:0]  s_a, s_b, mask;
        logic [W:0]    full, part;
        int            i;
        s_start = start; s_a = a; s_b = b; s_cin = cin; s_sub = sub;
        if (!rst_n) begin
            m_cnt = 0; e_sum = '0; e_cout = 1'b0; e_ovf = 1'b0;
        end else if ((m_cnt == 0 || m_cnt == WORDS + 1) && s_start) begin
            m_cnt = 1;
            m_a   = s_a;
            m_b   = s_b;
            m_c   = s_cin;
`ifdef CLA_SEQ_SUB_EN
            if (s_sub) begin
                m_b = ~s_b;
                m_c = 1'b1;
            end
`endif
        end else if (m_cnt >= 1 && m_cnt <= WORDS) begin
            m_cnt++;
            if (m_cnt == WORDS + 1) begin
                full   = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_c};
                e_sum  = full[W-1:0];
                e_cout = full[W];
                e_ovf  = (m_a[W-1] == m_b[W-1]) && (full[W-1] != m_a[W-1]);
            end
        end else begin
            m_cnt = 0;
        end
        #1;
        chk("busy", {{W{1'b0}}, busy}, {{W{1'b0}}, (m_cnt >= 1 && m_cnt <= WORDS)});
        chk("done", {{W{1'b0}}, done}, {{W{1'b0}}, (m_cnt == WORDS + 1)});
        if (m_cnt >= 1 && m_cnt <= WORDS) begin
            i    = m_cnt - 1;
            mask = (W'(1) << (16 * i)) - W'(1);
            part = {1'b0, m_a & mask} + {1'b0, m_b & mask} + {{W{1'b0}}, m_c};
            chk("cla_a",   {{(W-15){1'b0}}, cla_a},   {{(W-15){1'b0}}, m_a[16*i +: 16]});
            chk("cla_b",   {{(W-15){1'b0}}, cla_b},   {{(W-15){1'b0}}, m_b[16*i +: 16]});
            chk("cla_cin", {{W{1'b0}}, cla_cin},      {{W{1'b0}}, part[16*i]});
        end else begin
            chk("cla_idle", {{(W-32){1'b0}}, cla_a, cla_b, cla_cin}, '0);
            chk("sum",  {1'b0, sum},            {1'b0, e_sum});
            chk("cout", {{W{1'b0}}, cout},      {{W{1'b0}}, e_cout});
            chk("ovf",  {{W{1'b0}}, ovf},       {{W{1'b0}}, e_ovf});
        end
    end

    task automatic start_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic vc, input logic vs, input bit now);
        if (!now) @(negedge clk);
        start = 1'b1; a = va; b = vb; cin = vc; sub = vs;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                n = k;
                break;
            end
        end
        if (n == 0) chk("done_timeout", 0, 1);
    endtask

    task automatic check_result(input string nm, input logic [W-1:0] es,
                                input logic ec, input logic eo);
        chk({nm, "_sum"},  {1'b0, sum},       {1'b0, es});
        chk({nm, "_cout"}, {{W{1'b0}}, cout}, {{W{1'b0}}, ec});
        chk({nm, "_ovf"},  {{W{1'b0}}, ovf},  {{W{1'b0}}, eo});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {{W{1'b0}}, busy}, '0);
        chk("rst_done", {{W{1'b0}}, done}, '0);
        check_result("rst", 64'h0, 1'b0, 1'b0);
        rst_n = 1'b1;

        start_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        chk("latency", n, 4);
        check_result("carry16", 64'h0000_0000_0001_0000, 1'b0, 1'b0);

        start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1'b0);
        wait_done(n);
        check_result("ripple", 64'h0, 1'b1, 1'b0);

        start_op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        check_result("ovf", 64'h8000_0000_0000_0000, 1'b0, 1'b1);

        // start held through RUN with changing operands must be ignored
        @(negedge clk);
        start = 1'b1; a = 64'd10; b = 64'd20; cin = 1'b0;
        @(negedge clk);
        a = 64'hAAAA_AAAA_AAAA_AAAA; b = 64'h5555_5555_5555_5555;
        repeat (3) @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("held_done", {{W{1'b0}}, done}, {{W{1'b0}}, 1'b1});
        check_result("held", 64'd30, 1'b0, 1'b0);

        // back-to-back start issued in the DONE cycle
        start_op(64'd3, 64'd4, 1'b0, 1'b0, 1'b1);
        wait_done(n);
        chk("b2b_latency", n, 4);
        check_result("b2b", 64'd7, 1'b0, 1'b0);

        // reset mid-RUN after two slices captured
        start_op(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {{W{1'b0}}, busy}, '0);
        chk("midrst_done", {{W{1'b0}}, done}, '0);
        check_result("midrst", 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
        wait_done(n);
        check_result("post_rst", 64'd3, 1'b0, 1'b0);

`ifdef CLA_SEQ_SUB_EN
        start_op(64'd5, 64'd7, 1'b0, 1'b1, 1'b0);
        wait_done(n);
        check_result("sub", 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
